// File: rtl/piso_pkg.sv
// Shared types and constants for the bidirectional parallel-in/serial-out register.
package piso_pkg;

   typedef enum logic {
      StIdle,
      StShift
   } state_e;

   localparam logic DIR_MSB_FIRST = 1'b0;
   localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/bidirectional_piso_if.sv
// Load handshake and serial output bundle for bidirectional_piso.
// PISO_PARITY_EN adds the s_parity marker.
interface bidirectional_piso_if #(
   parameter int unsigned WIDTH = 4
);

   logic             load_valid;
   logic             load_ready;
   logic [WIDTH-1:0] d_in;
   logic             direction;
   logic             en;
   logic             s_out;
   logic             s_valid;
   logic             busy;
   logic             done;
`ifdef PISO_PARITY_EN
   logic             s_parity;
`endif

   // Driven by the producer/consumer side.
   modport master (
      output load_valid,
      output d_in,
      output direction,
      output en,
      input  load_ready,
      input  s_out,
      input  s_valid,
      input  busy,
      input  done
`ifdef PISO_PARITY_EN
      ,
      input  s_parity
`endif
   );

   // The serializer itself.
   modport slave (
      input  load_valid,
      input  d_in,
      input  direction,
      input  en,
      output load_ready,
      output s_out,
      output s_valid,
      output busy,
      output done
`ifdef PISO_PARITY_EN
      ,
      output s_parity
`endif
   );

endinterface

// File: rtl/bidirectional_piso.sv
// Parallel-in, serial-out shift register, MSB- or LSB-first, with one-cycle done pulse.
// Defining PISO_PARITY_EN appends an even-parity bit to every frame.
module bidirectional_piso
   import piso_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input logic                clk,
   input logic                rst,
   bidirectional_piso_if.slave bus
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);
`ifdef PISO_PARITY_EN
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);
`else
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
`endif

   state_e           r_state, w_state_d;
   logic [WIDTH-1:0] r_sr,    w_sr_d;
   logic [CNT_W-1:0] r_cnt,   w_cnt_d;
   logic             r_dir,   w_dir_d;
   logic             r_done,  w_done_d;
`ifdef PISO_PARITY_EN
   logic             r_par,   w_par_d;
   logic             w_par_slot;
`endif

   logic w_shift;
   logic w_head;
   logic w_bit;
   logic w_last;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= StIdle;
         r_sr    <= '0;
         r_cnt   <= '0;
         r_dir   <= DIR_MSB_FIRST;
         r_done  <= 1'b0;
`ifdef PISO_PARITY_EN
         r_par   <= 1'b0;
`endif
      end else begin
         r_state <= w_state_d;
         r_sr    <= w_sr_d;
         r_cnt   <= w_cnt_d;
         r_dir   <= w_dir_d;
         r_done  <= w_done_d;
`ifdef PISO_PARITY_EN
         r_par   <= w_par_d;
`endif
      end
   end

   assign w_shift = (r_state == StShift);
   assign w_head  = (r_dir == DIR_LSB_FIRST) ? r_sr[0] : r_sr[WIDTH-1];
   assign w_last  = (r_cnt == LAST_CNT);

`ifdef PISO_PARITY_EN
   // Once all data bits are consumed the register is empty and the parity slot follows.
   assign w_par_slot   = w_shift && (r_cnt == CNT_W'(WIDTH));
   assign w_bit        = w_par_slot ? r_par : w_head;
   assign bus.s_parity = w_par_slot;
`else
   assign w_bit = w_head;
`endif

   always_comb begin
      w_state_d = r_state;
      w_sr_d    = r_sr;
      w_cnt_d   = r_cnt;
      w_dir_d   = r_dir;
      w_done_d  = 1'b0;
`ifdef PISO_PARITY_EN
      w_par_d   = r_par;
`endif
      unique case (r_state)
         StIdle: begin
            if (bus.load_valid) begin
               w_sr_d    = bus.d_in;
               w_dir_d   = bus.direction;
               w_cnt_d   = '0;
               w_state_d = StShift;
`ifdef PISO_PARITY_EN
               w_par_d   = ^bus.d_in;
`endif
            end
         end
         StShift: begin
            if (bus.en) begin
               w_sr_d = (r_dir == DIR_LSB_FIRST) ? (r_sr >> 1) : (r_sr << 1);
               // Counter parks at the terminal count rather than wrapping.
               if (w_last) begin
                  w_state_d = StIdle;
                  w_done_d  = 1'b1;
               end else begin
                  w_cnt_d = r_cnt + 1'b1;
               end
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   assign bus.load_ready = (r_state == StIdle);
   assign bus.busy       = w_shift;
   assign bus.s_valid    = w_shift;
   assign bus.s_out      = w_shift & w_bit;
   assign bus.done       = r_done;

endmodule

// File: doc/bidirectional_piso.md
Name: bidirectional_piso

Overview:
- Parallel-in, serial-out shift register with selectable bit order; the transmit-side counterpart of the team's bidirectional serial-in/parallel-out register.
- Accepts a WIDTH-bit word through a valid/ready load handshake and emits it one bit per enabled cycle, MSB-first or LSB-first.
- Signals completion with a one-cycle done pulse.
- Sits between a parallel producer and any serial link or SIPO receiver in the design.

Parameters:
- WIDTH, 4, data word width in bits; legal range 2 to 32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- load_valid  input  1  producer presents a word on d_in.
- load_ready  output  1  block can accept a word; high only in IDLE.
- d_in  input  WIDTH  parallel word to serialize.
- direction  input  1  bit order, sampled on load: 0 = MSB-first (shift left), 1 = LSB-first (shift right).
- en  input  1  shift strobe; one bit is consumed per cycle while en=1 in SHIFT.
- s_out  output  1  current serial bit.
- s_valid  output  1  s_out holds a valid bit (state SHIFT).
- busy  output  1  high in SHIFT.
- done  output  1  one-cycle pulse after the last bit is consumed.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-low. While rst=0: state=IDLE, shift register=0, bit counter=0, dir_q=0, done=0. Reset outputs: s_out=0, s_valid=0, busy=0, load_ready=1.
- States: IDLE and SHIFT.
- IDLE:
  - load_ready=1.
  - On a rising edge with load_valid=1: sr<=d_in, dir_q<=direction, cnt<=0, state<=SHIFT.
  - The new bit is visible on s_out in the following cycle.
- SHIFT:
  - load_ready=0; load_valid is ignored and no word is accepted.
  - s_out is combinational from the head of the register: sr[WIDTH-1] when dir_q=0, sr[0] when dir_q=1.
  - On an edge with en=1:
    - Shift sr toward the head by one position and fill with 0.
    - cnt<=cnt+1.
    - If cnt==WIDTH-1 (last bit): state<=IDLE and done<=1 for exactly the next cycle.
  - With en=0, sr, cnt and s_out hold indefinitely (stall).
- direction changes during SHIFT have no effect; only dir_q is used.
- Latency: the first bit appears on s_out 1 cycle after load acceptance. A word with en held high takes WIDTH cycles. done is high in the cycle after the last bit, coincident with load_ready returning high.
- Back-to-back: a new load can be accepted in the same cycle done is high. Minimum gap between words is therefore one cycle.
- cnt is sized clog2(WIDTH+1) bits and never wraps past the terminal count.
- Reset mid-word: the word is aborted immediately, done is not pulsed, and all state is cleared as above.
- s_out is forced to 0 when s_valid=0.

Optional Feature:
- Macro: PISO_PARITY_EN.
- When defined:
  - At load, even parity of d_in (XOR-reduce) is captured into a parity register.
  - After the WIDTH data bits, one extra enabled cycle outputs the parity bit on s_out with s_valid=1.
  - The frame is WIDTH+1 bits; terminal count becomes WIDTH, and done follows the parity bit.
  - An extra output port s_parity (1 bit) is high while the parity bit is presented.
- When undefined: no parity register and no s_parity port; the frame is exactly WIDTH bits.

Decomposition:
- Shared package piso_pkg:
  - state enum (IDLE, SHIFT);
  - constants DIR_MSB_FIRST=1'b0 and DIR_LSB_FIRST=1'b1.
- No sub-module. The counter and shift register are small enough to stay inline.

Test Plan (WIDTH=4):
- Load 4'b1011, direction=0, en=1 continuously -> s_out 1,0,1,1 on 4 consecutive cycles with s_valid=1; done high in the 5th cycle; load_ready high again in that cycle.
- Load 4'b1011, direction=1, en=1 -> s_out 1,1,0,1; done after the 4th bit.
- Load 4'b1100, direction=0, en pattern 1,0,0,1,1,1 -> s_out holds 1 during the two stall cycles; overall sequence 1,1,0,0; done once.
- Load 4'b0110; assert load_valid with 4'b1111 and toggle direction during SHIFT -> second word not accepted; output 0,1,1,0 unchanged.
- Load 4'b1111, drop rst after 2 bits -> s_out=0, s_valid=0, load_ready=1 asynchronously; no done pulse; a fresh load of 4'b1000 then serializes correctly.
- PISO_PARITY_EN defined: load 4'b1011, direction=0 -> s_out 1,0,1,1,1 with s_parity high on the 5th bit only; done in the 6th cycle. Load 4'b0101 -> parity bit 0.
